// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  function automatic logic is_session(input state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects little-endian stream bytes into instruction words; word_valid flags the
// transfer that completes a word, with word carrying that byte in its top lane.
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          byte_en,
  input  logic [7:0]                    byte_in,
  output logic                          word_valid,
  output logic [BYTES_PER_WORD*8-1:0]   word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]                  byte_idx;
  logic [(BYTES_PER_WORD-1)*8-1:0]   lanes;

  // The lower lanes shift in from the top, so after three bytes they hold b2,b1,b0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + IDX_W'(1);
      lanes    <= {byte_in, lanes[(BYTES_PER_WORD-1)*8-1:8]};
    end
  end

  assign word_valid = byte_en && (byte_idx == LAST_IDX);
  assign word       = {byte_in, lanes};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a word-count header, writes the following words to
// instruction memory, and holds the core in reset until the load succeeds.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int DEPTH         = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0]    mem_wdata,
  output logic                      cpu_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int WIDX_W = $clog2(DEPTH) + 1;
  localparam int HDR_W  = HDR_BYTES * 8;

  state_t             state, next_state;
  logic [HDR_W-1:0]   n_count;
  logic [HDR_W-1:0]   hdr_n;
  logic [WIDX_W-1:0]  word_idx;
  logic               xfer;
  logic               start_ok;
  logic               last_word;
  logic               asm_valid;
  logic [BYTES_PER_WORD*8-1:0] asm_word;

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign hdr_n     = {byte_in, n_count[7:0]};
  assign last_word = (HDR_W'(word_idx) == (n_count - HDR_W'(1)));

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_en    (xfer && (state == DATA)),
    .byte_in    (byte_in),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = HDR_LO;
      HDR_LO:          if (xfer) next_state = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr_n == '0)                  next_state = DONE;
          else if (hdr_n > HDR_W'(DEPTH))   next_state = ERR;
          else                              next_state = DATA;
        end
      end
      DATA:    if (asm_valid && last_word) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // byte_ready/busy follow next_state so the stream closes in the same cycle as the final write;
  // done/cpu_rst_n follow state, so they rise one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_count    <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      byte_ready <= is_session(next_state);
      busy       <= is_session(next_state);
      mem_we     <= asm_valid;
      done       <= (state == DONE) && !start_ok;
      err        <= (state == ERR) && !start_ok;
      cpu_rst_n  <= (state == DONE) && !start_ok;

      if (state == HDR_LO && xfer) n_count[7:0]  <= byte_in;
      if (state == HDR_HI && xfer) n_count[15:8] <= byte_in;

      if (start_ok) begin
        word_idx <= '0;
      end else if (asm_valid) begin
        word_idx  <= word_idx + WIDX_W'(1);
        mem_addr  <= ADDRESS_WIDTH'({word_idx, 2'b00});
        mem_wdata <= INSTR_WIDTH'(asm_word);
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the 64-word instruction memory at boot. Receives a byte stream over a valid/ready handshake, assembles 32-bit little-endian instruction words, and drives the memory write port.
- Holds the processor core in reset until the whole program is written.
- Sits between an external byte source (UART receiver or test harness) and the instruction memory write port; the core's fetch path is untouched.

Parameters:
- ADDRESS_WIDTH, 32, width of the byte address driven to instruction memory.
- INSTR_WIDTH, 32, instruction word width. Fixed at 32: four bytes per word.
- DEPTH, 64, number of instruction words in memory. Upper bound on the loaded word count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load session.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle. Transfer occurs when byte_valid && byte_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDRESS_WIDTH  byte address of the word being written; always word aligned, bits [1:0] = 0.
- mem_wdata  output  INSTR_WIDTH  assembled word.
- cpu_rst_n  output  1  active-low reset to the core; released only after a successful load.
- busy  output  1  session in progress (states HDR_LO, HDR_HI, DATA).
- done  output  1  last session completed successfully (sticky).
- err  output  1  last session rejected (sticky).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0; all internal counters 0.
- States: IDLE, HDR_LO, HDR_HI, DATA, DONE, ERR. All outputs are registered.
- Session format: 16-bit word count N, sent low byte first; then 4*N data bytes. Each word is sent least-significant byte first.
- start is honoured only in IDLE, DONE and ERR, and is ignored while busy. On start:
  - next state HDR_LO;
  - cpu_rst_n=0, done=0, err=0;
  - word index and byte index cleared.
- HDR_LO: byte_ready=1. On transfer, latch N[7:0] and go to HDR_HI.
- HDR_HI: byte_ready=1. On transfer, latch N[15:8], then:
  - N==0 -> DONE;
  - N>DEPTH -> ERR;
  - otherwise -> DATA.
- DATA: byte_ready=1 continuously; the write pulse never stalls the stream.
  - Each transfer shifts byte_in into a 32-bit assembly register at lane byte_idx; byte_idx wraps 3->0.
  - On the transfer with byte_idx==3, the next cycle has mem_we=1, mem_wdata = assembled word, mem_addr = word_idx*4.
  - word_idx increments in that same cycle.
  - mem_we is exactly one cycle wide and is 0 otherwise. mem_addr and mem_wdata hold their values between writes.
- Completion: when the word written is word N-1, the next state is DONE. DONE is entered in the same cycle mem_we is asserted, so cpu_rst_n rises one cycle after the final mem_we.
- DONE: byte_ready=0, done=1, cpu_rst_n=1.
- ERR: byte_ready=0, err=1, cpu_rst_n=0. No memory writes occur.
- Gaps in byte_valid are legal at any point; no timeout.
- Bytes presented while byte_ready=0 are not consumed.
- Asserting rst_n low mid-session aborts immediately: back to reset values, with no partial write for a partially assembled word.
- Widths: word_idx is clog2(DEPTH)+1 bits; N is compared at 16 bits.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, HDR_LO, HDR_HI, DATA, DONE, ERR);
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2.
- One natural sub-module, imem_word_assembler: byte lane shift register plus byte_idx counter, emitting word_valid and word.
- The FSM, word counter and address generation remain in the top module.

Test Plan:
- Reset: hold rst_n=0, then release -> all outputs 0, byte_ready=0, cpu_rst_n=0; no mem_we until start.
- Nominal load: start; stream 02 00, then 13 05 A0 00, then 93 05 10 00.
  - First write: mem_we at addr 0x0, data 0x00A00513.
  - Second write: mem_we at addr 0x4, data 0x00100593.
  - done=1 and cpu_rst_n=1 one cycle after the second mem_we.
- Throttled stream: same payload with byte_valid low for 3 cycles between every byte -> identical writes and data; exactly 2 mem_we pulses.
- Oversize / zero count:
  - header 41 00 (N=65) -> err=1, cpu_rst_n stays 0, no mem_we, byte_ready=0.
  - new start with header 00 00 -> done=1 immediately, no mem_we.
- Full depth: N=64 words with data = index -> last write addr 0xFC, data 0x0000003F; done=1.
- Abort and restart:
  - pull rst_n low after 2 of 4 bytes of word 1 -> no write, outputs return to reset values;
  - a later full session loads correctly;
  - a start pulse during DATA is ignored.
